clock24_counter: RTL and testbench

- Free-running 24-hour timekeeper that sits directly downstream of the hour/minute setting FSM.
- Consumes that FSM's one-cycle commit pulse plus its hours/minutes values, loads them, then counts HH:MM:SS from a prescaled system clock.
- Outputs drive the display/mux stage and any alarm comparator.

---
 rtl/clock_pkg.sv | 41 ++++
 rtl/tick_divider.sv | 31 +++
 rtl/clock24_counter.sv | 72 +++++++
 tb/tb_clock24_counter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Time-of-day widths, limits and carry helpers shared by the setting FSM,
// the timekeeper and the display stages.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

  typedef struct packed {
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  minutes;
    logic [SEC_W-1:0]  seconds;
  } tod_t;

  // One-second advance with the whole HH:MM:SS carry chain resolved at once.
  function automatic tod_t tod_advance(input tod_t t);
    tod_t n;
    n = t;
    if (t.seconds != SEC_MAX) begin
      n.seconds = t.seconds + SEC_W'(1);
    end else begin
      n.seconds = '0;
      if (t.minutes != MIN_MAX) begin
        n.minutes = t.minutes + MIN_W'(1);
      end else begin
        n.minutes = '0;
        n.hours   = (t.hours == HOUR_MAX) ? '0 : t.hours + HOUR_W'(1);
      end
    end
    return n;
  endfunction

  function automatic logic tod_is_last(input tod_t t);
    return (t.hours == HOUR_MAX) && (t.minutes == MIN_MAX) && (t.seconds == SEC_MAX);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler: counts enabled cycles and flags the edge that completes a second.
module tick_divider #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // High when the coming edge closes the second; the count itself is registered.
  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clock24_counter.sv
// 24-hour HH:MM:SS timekeeper loaded by the setting FSM's commit pulse.
module clock24_counter
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRESCALE_W    = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [HOUR_W-1:0] load_hours,
  input  logic [MIN_W-1:0]  load_minutes,
  input  logic              run_enable,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic              sec_pulse,
  output logic              day_wrap
);

  tod_t tod_q, tod_d;
  logic sec_pulse_q, sec_pulse_d;
  logic day_wrap_q, day_wrap_d;
  logic div_tick;

  // Load clears the prescaler too, so the next second is a full one.
  tick_divider #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .CNT_W        (PRESCALE_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .enable(run_enable),
    .clear (load),
    .tick  (div_tick)
  );

  always_comb begin
    tod_d       = tod_q;
    sec_pulse_d = 1'b0;
    day_wrap_d  = 1'b0;
    if (load) begin
      // Load beats a coincident tick; bad fields clamp to zero independently.
      tod_d.hours   = (load_hours   > HOUR_MAX) ? '0 : load_hours;
      tod_d.minutes = (load_minutes > MIN_MAX)  ? '0 : load_minutes;
      tod_d.seconds = '0;
    end else if (div_tick) begin
      tod_d       = tod_advance(tod_q);
      sec_pulse_d = 1'b1;
      day_wrap_d  = tod_is_last(tod_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tod_q       <= '0;
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
    end else begin
      tod_q       <= tod_d;
      sec_pulse_q <= sec_pulse_d;
      day_wrap_q  <= day_wrap_d;
    end
  end

  assign hours     = tod_q.hours;
  assign minutes   = tod_q.minutes;
  assign seconds   = tod_q.seconds;
  assign sec_pulse = sec_pulse_q;
  assign day_wrap  = day_wrap_q;

endmodule

// File: tb/tb_clock24_counter.sv
// Self-checking bench: directed scenarios plus random load/run traffic,
// compared every cycle against a seconds-of-day reference model.
module tb_clock24_counter;

  localparam int TPS = 4;
  localparam int DAY = 86400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld  = 1'b0;
  logic [4:0] ldh = '0;
  logic [5:0] ldm = '0;
  logic       run = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_pulse;
  logic       day_wrap;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: elapsed seconds since midnight plus prescale phase.
  int m_t = 0;
  int m_pre = 0;
  int m_pulse = 0;
  int m_wrap = 0;

  clock24_counter #(
    .TICKS_PER_SEC(TPS),
    .PRESCALE_W   (3)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .load        (ld),
    .load_hours  (ldh),
    .load_minutes(ldm),
    .run_enable  (run),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .sec_pulse   (sec_pulse),
    .day_wrap    (day_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_t = 0; m_pre = 0; m_pulse = 0; m_wrap = 0;
    end else if (ld) begin
      m_t = ((ldh > 23) ? 0 : int'(ldh)) * 3600 + ((ldm > 59) ? 0 : int'(ldm)) * 60;
      m_pre = 0; m_pulse = 0; m_wrap = 0;
    end else if (run && m_pre == TPS - 1) begin
      m_wrap  = (m_t == DAY - 1) ? 1 : 0;
      m_t     = (m_t + 1) % DAY;
      m_pre   = 0;
      m_pulse = 1;
    end else begin
      if (run) m_pre++;
      m_pulse = 0; m_wrap = 0;
    end
  endtask

  task automatic check_all();
    chk("hours",     int'(hours),     m_t / 3600);
    chk("minutes",   int'(minutes),   (m_t / 60) % 60);
    chk("seconds",   int'(seconds),   m_t % 60);
    chk("sec_pulse", int'(sec_pulse), m_pulse);
    chk("day_wrap",  int'(day_wrap),  m_wrap);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_load(input int h, input int m);
    ld = 1'b1; ldh = 5'(h); ldm = 6'(m);
    step();
    ld = 1'b0;
  endtask

  initial begin
    int npulse;
    int nwrap;

    // 1. reset then run
    #1;
    check_all();
    step(); step();
    rst = 1'b0; run = 1'b1;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      npulse += int'(sec_pulse);
      if (i % 4 == 3) chk("t1_pulse_slot", int'(sec_pulse), 1);
    end
    chk("t1_pulses", npulse, 3);
    chk("t1_seconds", int'(seconds), 3);

    // 2. full rollover from 23:59
    do_load(23, 59);
    nwrap = 0;
    for (int i = 0; i < 60 * TPS; i++) begin
      step();
      nwrap += int'(day_wrap);
    end
    chk("t2_wraps", nwrap, 1);
    chk("t2_h", int'(hours), 0);
    chk("t2_m", int'(minutes), 0);
    chk("t2_s", int'(seconds), 0);
    chk("t2_pulse", int'(sec_pulse), 1);
    chk("t2_wrap", int'(day_wrap), 1);

    // 3. minute/hour carry without day wrap
    do_load(5, 59);
    nwrap = 0;
    for (int i = 0; i < 60 * TPS; i++) begin
      step();
      nwrap += int'(day_wrap);
    end
    chk("t3_wraps", nwrap, 0);
    chk("t3_h", int'(hours), 6);
    chk("t3_m", int'(minutes), 0);
    chk("t3_s", int'(seconds), 0);
    do_load(12, 34);
    for (int i = 0; i < TPS; i++) step();
    chk("t3b_time", int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds), 12 * 3600 + 34 * 60 + 1);

    // 4. freeze mid-second and resume
    do_load(1, 2);
    step(); step();
    run = 1'b0;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      npulse += int'(sec_pulse);
    end
    chk("t4_frozen_pulses", npulse, 0);
    chk("t4_frozen_s", int'(seconds), 0);
    run = 1'b1;
    step();
    chk("t4_resume_early", int'(sec_pulse), 0);
    step();
    chk("t4_resume_tick", int'(sec_pulse), 1);
    chk("t4_resume_s", int'(seconds), 1);

    // 5. load on the tick edge, then clamp
    do_load(0, 0);
    step(); step(); step();
    do_load(7, 30);
    chk("t5_collide_pulse", int'(sec_pulse), 0);
    chk("t5_collide_time", int'(hours) * 100 + int'(minutes), 730);
    do_load(25, 61);
    chk("t5_clamp", int'(hours) + int'(minutes) + int'(seconds), 0);
    do_load(25, 45);
    chk("t5_clamp_h", int'(hours), 0);
    chk("t5_keep_m", int'(minutes), 45);

    // 6. async reset between edges
    do_load(10, 20);
    for (int i = 0; i < 30 * TPS; i++) step();
    chk("t6_pre_s", int'(seconds), 30);
    #2;
    rst = 1'b1;
    m_t = 0; m_pre = 0; m_pulse = 0; m_wrap = 0;
    #1;
    check_all();
    step();
    rst = 1'b0;

    // random load / enable traffic
    for (int i = 0; i < 1500; i++) begin
      run = ($urandom_range(0, 9) < 8);
      ld  = ($urandom_range(0, 29) == 0);
      ldh = 5'($urandom_range(0, 31));
      ldm = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) begin
        ldh = 5'd23; ldm = 6'd59;
      end
      step();
    end
    ld = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
